// File: rtl/flit_pkg.sv
// ----------------------------------------------------------------------------
// flit_pkg
// Shared definitions for the flit injection network interface:
//   - flit field layout: [19:4] payload, [3:2] reserved (0), [1:0] dest_local
//   - state_t: injection FSM states
//   - field-extract helpers used by the top level and by checkers
// ----------------------------------------------------------------------------
package flit_pkg;

    localparam int FLIT_W      = 20;
    localparam int PAYLOAD_LSB = 4;
    localparam int PAYLOAD_W   = FLIT_W - PAYLOAD_LSB;
    localparam int DEST_LSB    = 0;
    localparam int DEST_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] f);
        return f[DEST_LSB +: DEST_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] flit_payload(input logic [FLIT_W-1:0] f);
        return f[PAYLOAD_LSB +: PAYLOAD_W];
    endfunction

endpackage

// File: rtl/flit_if.sv
// ----------------------------------------------------------------------------
// flit_if
// Injection port from the network interface into the local router input.
//   out_flit  : flit presented to the router
//   out_dest  : out_flit[1:0], used by the router for port select
//   out_valid : out_flit is valid
//   out_ready : router accepts the flit this cycle
// Handshake: a flit transfers on every clock edge where out_valid && out_ready
// are both high. While out_valid is high and out_ready is low, the master
// holds out_flit/out_dest stable and keeps out_valid high; out_valid never
// depends combinationally on out_ready.
// master = network interface side, slave = router side.
// ----------------------------------------------------------------------------
interface flit_if #(
    parameter int FLIT_W = 20
);
    import flit_pkg::*;

    logic [FLIT_W-1:0] out_flit;
    logic [DEST_W-1:0] out_dest;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_flit,
        output out_dest,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_flit,
        input  out_dest,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Small first-word-fall-through FIFO holding captured flits.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push, wdata  : write request and data
//   pop          : head consumed this cycle (ignored when empty)
//   head         : current head entry, forced to 0 while empty
//   full, empty  : derived from the occupancy counter
//   accepted     : the push request is written this cycle
//   count        : current occupancy (0..DEPTH)
//   count_next   : occupancy after this edge
// A push into a full FIFO is still accepted when a pop happens the same
// cycle, because the slot being vacated is reused.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int FLIT_W = 20,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] wdata,
    output logic [FLIT_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              accepted,
    output logic [AW:0]       count,
    output logic [AW:0]       count_next
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_en;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_en   = pop && !empty;
    assign accepted = push && (!full || pop_en);

    // Gate the head with empty so the stale (unreset) storage never leaks out.
    assign head = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({accepted, pop_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/flit_inject_ni.sv
// ----------------------------------------------------------------------------
// flit_inject_ni
// Network-interface injection stage. Enables the per-node ROM stimulus
// buffer, captures its flit stream into a FWFT FIFO, presents flits to the
// local router over the rtr valid/ready port and reports when the burst of
// BURST_LEN flits has fully drained.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a run from IDLE or DONE
//   src_enable   : registered enable to the source buffer
//   src_data     : flit from the source, src_valid qualifies it
//   rtr          : flit_if master port towards the router
//   busy         : state is RUN or DRAIN
//   done         : state is DONE
//   rx_count     : flits captured this run (saturates at 31)
//   drop_count   : flits lost to overflow (saturates at 255)
//   overflow     : sticky, set on the first drop
//   dest_cnt     : per-destination transfer counters, 4 x 5 bits,
//                  [4:0] = dest 0 (only with FLIT_INJECT_DEST_CNT_EN)
//   dbg_state    : current FSM state
// Optional build macro: FLIT_INJECT_DEST_CNT_EN adds dest_cnt.
// ----------------------------------------------------------------------------
module flit_inject_ni
    import flit_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 30,
    parameter int FLIT_W    = flit_pkg::FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              src_enable,
    input  logic [FLIT_W-1:0] src_data,
    input  logic              src_valid,
    flit_if.master            rtr,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rx_count,
    output logic [7:0]        drop_count,
    output logic              overflow,
`ifdef FLIT_INJECT_DEST_CNT_EN
    output logic [19:0]       dest_cnt,
`endif
    output state_t            dbg_state
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] EN_LIMIT = (AW+1)'(DEPTH - 3);
    localparam logic [4:0]  BURST_C  = 5'(BURST_LEN);

    state_t            state;
    state_t            state_n;
    logic [FLIT_W-1:0] head;
    logic              full;
    logic              empty;
    logic              accepted;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              pop;
    logic              drop;
    logic              start_acc;
    logic              en_next;
    logic [4:0]        rx_n;
    logic [7:0]        drop_n;
    logic              ovf_n;

    // ---------------------------------------------------------------- FIFO
    sync_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (src_valid),
        .pop        (pop),
        .wdata      (src_data),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .accepted   (accepted),
        .count      (count),
        .count_next (count_next)
    );

    assign rtr.out_valid = !empty;
    assign rtr.out_flit  = head;
    assign rtr.out_dest  = flit_dest(head);
    assign pop           = rtr.out_valid && rtr.out_ready;

    // Capture is independent of state and of src_enable: anything the source
    // presents is either stored or counted as a drop.
    assign drop      = src_valid && !accepted;
    assign start_acc = start && ((state == IDLE) || (state == DONE));

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_acc) state_n = RUN;
            RUN:     if (rx_count >= BURST_C) state_n = DRAIN;
            DRAIN:   if (empty && !accepted) state_n = DONE;
            DONE:    if (start_acc) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Two slots of headroom: one for the flit already requested by the
    // current enable (one-cycle source latency) and one in flight.
    assign en_next = (state_n == RUN) && (count_next <= EN_LIMIT);

    // ------------------------------------------------------------ counters
    // A start clears the run counters; a capture in the same cycle still
    // counts towards the new run.
    always_comb begin
        rx_n   = start_acc ? 5'd0 : rx_count;
        drop_n = start_acc ? 8'd0 : drop_count;
        ovf_n  = start_acc ? 1'b0 : overflow;
        if (accepted && (rx_n != 5'd31)) rx_n = rx_n + 5'd1;
        if (drop) begin
            if (drop_n != 8'hFF) drop_n = drop_n + 8'd1;
            ovf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_enable <= 1'b0;
            rx_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            src_enable <= en_next;
            rx_count   <= rx_n;
            drop_count <= drop_n;
            overflow   <= ovf_n;
        end
    end

`ifdef FLIT_INJECT_DEST_CNT_EN
    // ------------------------------------------- per-destination counters
    logic [19:0] dest_cnt_n;

    always_comb begin
        dest_cnt_n = start_acc ? 20'd0 : dest_cnt;
        for (int d = 0; d < 4; d++) begin
            if (pop && (rtr.out_dest == 2'(d)) && (dest_cnt_n[d*5 +: 5] != 5'd31))
                dest_cnt_n[d*5 +: 5] = dest_cnt_n[d*5 +: 5] + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dest_cnt <= '0;
        else      dest_cnt <= dest_cnt_n;
    end
`endif

endmodule

// File: tb/tb_flit_inject_ni.sv
// ----------------------------------------------------------------------------
// tb_flit_inject_ni
// Directed bench for flit_inject_ni. A behavioural ROM source (one-cycle
// enable-to-valid latency, 30 flits 0x01010 .. 0x011E1) feeds the DUT; every
// router transfer is checked against an expected queue.
// ----------------------------------------------------------------------------
module tb_flit_inject_ni;
    import flit_pkg::*;

    localparam int N_FLITS = 30;

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start;
    logic        src_enable;
    logic [19:0] src_data;
    logic        src_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [4:0]  rx_count;
    logic [7:0]  drop_count;
    logic        overflow;
    state_t      dbg_state;
`ifdef FLIT_INJECT_DEST_CNT_EN
    logic [19:0] dest_cnt;
`endif
    logic [19:0] out_flit;
    logic [1:0]  out_dest;
    logic        out_valid;

    flit_if #(.FLIT_W(20)) rtr_if ();

    assign rtr_if.out_ready = out_ready;
    assign out_flit  = rtr_if.out_flit;
    assign out_dest  = rtr_if.out_dest;
    assign out_valid = rtr_if.out_valid;

    flit_inject_ni #(
        .DEPTH     (8),
        .BURST_LEN (30),
        .FLIT_W    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_enable (src_enable),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .rtr        (rtr_if),
        .busy       (busy),
        .done       (done),
        .rx_count   (rx_count),
        .drop_count (drop_count),
        .overflow   (overflow),
`ifdef FLIT_INJECT_DEST_CNT_EN
        .dest_cnt   (dest_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------------------------------------------------- scoreboard
    logic [19:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          src_idx  = 0;
    int          xfer_cnt = 0;
    bit          force_mode = 1'b0;
    logic [19:0] force_data = 20'h0A000;
    bit          prev_stall = 1'b0;
    logic [19:0] prev_flit  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] flit_of(input int i);
        logic [15:0] p;
        logic [1:0]  d;
        p = 16'h0101 + 16'(i);
        d = 2'(i);
        return {p, 2'b00, d};
    endfunction

    // ------------------------------------------------------------- driver
    // One clock: check the transfer about to happen, advance, then update
    // the source model from the enable it saw before the edge.
    task automatic tick();
        logic        en_s;
        logic [19:0] e;
        if (prev_stall) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_flit", 32'(out_flit), 32'(prev_flit));
        end
        if (out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("extra_flit", 32'(out_flit), 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("xfer_flit", 32'(out_flit), 32'(e));
                check_eq("xfer_dest", 32'(out_dest), 32'(e[1:0]));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_flit  = out_flit;
        en_s = src_enable;
        @(posedge clk);
        #1;
        if (force_mode) begin
            src_valid  = 1'b1;
            src_data   = force_data;
            force_data = force_data + 20'd1;
        end else if (en_s && (src_idx < N_FLITS)) begin
            src_valid = 1'b1;
            src_data  = flit_of(src_idx);
            src_idx++;
        end else begin
            src_valid = 1'b0;
        end
    endtask

    task automatic start_run();
        exp_q.delete();
        for (int i = 0; i < N_FLITS; i++) exp_q.push_back(flit_of(i));
        src_idx  = 0;
        xfer_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: out_ready held high, mode 1: out_ready random 50%
    task automatic run_to_done(input string tag, input int mode);
        int n;
        n = 0;
        while (!done && (n < 600)) begin
            out_ready = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            tick();
            n++;
        end
        out_ready = 1'b1;
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_rx"}, 32'(rx_count), 32'd30);
        check_eq({tag, "_drop"}, 32'(drop_count), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_xfers"}, 32'(xfer_cnt), 32'd30);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_flit"}, 32'(out_flit), 32'd0);
        check_eq({tag, "_dest"}, 32'(out_dest), 32'd0);
        check_eq({tag, "_en"}, 32'(src_enable), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_rx"}, 32'(rx_count), 32'd0);
        check_eq({tag, "_drop"}, 32'(drop_count), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check_idle("rst");
        exp_q.delete();
        src_valid  = 1'b0;
        src_data   = '0;
        src_idx    = 0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ----------------------------------------------------------- sequence
    initial begin
        int n;
        rst = 1'b0;
        start = 1'b0;
        src_valid = 1'b0;
        src_data = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();
        tick();

        // Full run, router always ready.
        out_ready = 1'b1;
        start_run();
        run_to_done("run1", 0);
`ifdef FLIT_INJECT_DEST_CNT_EN
        check_eq("dest_cnt", 32'(dest_cnt), 32'({5'd7, 5'd7, 5'd8, 5'd8}));
`endif

        // Router stalled 40 cycles: throttle must hold occupancy at 7.
        out_ready = 1'b0;
        start_run();
        repeat (40) tick();
        check_eq("stall_rx", 32'(rx_count), 32'd7);
        check_eq("stall_en", 32'(src_enable), 32'd0);
        check_eq("stall_ovf", 32'(overflow), 32'd0);
        check_eq("stall_drop", 32'(drop_count), 32'd0);
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_head", 32'(out_flit), 32'(flit_of(0)));
        run_to_done("run2", 0);

        // Random backpressure.
        start_run();
        run_to_done("run3", 1);

        // Reset mid-run after 10 transfers, then a clean full run.
        out_ready = 1'b1;
        start_run();
        n = 0;
        while ((xfer_cnt < 10) && (n < 200)) begin
            tick();
            n++;
        end
        check_eq("mid_xfers", 32'(xfer_cnt), 32'd10);
        apply_reset();
        tick();
        start_run();
        run_to_done("run4", 0);

        // Forced source in IDLE with the router stalled: 8 kept, 4 dropped.
        out_ready = 1'b0;
        apply_reset();
        tick();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(20'h0A000 + 20'(i));
        force_data = 20'h0A001;
        src_valid  = 1'b1;
        src_data   = 20'h0A000;
        force_mode = 1'b1;
        repeat (11) tick();
        force_mode = 1'b0;
        tick();
        check_eq("force_rx", 32'(rx_count), 32'd8);
        check_eq("force_drop", 32'(drop_count), 32'd4);
        check_eq("force_ovf", 32'(overflow), 32'd1);
        check_eq("force_valid", 32'(out_valid), 32'd1);
        check_eq("force_state", 32'(dbg_state), 32'(IDLE));
        out_ready = 1'b1;
        repeat (10) tick();
        check_eq("force_left", 32'(exp_q.size()), 32'd0);
        check_eq("force_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
